// File: rtl/load_align_unit.sv
// load_align_unit: handshaked load unit that reads aligned memory words and returns the
// addressed bytes zero/sign-extended. Define LOAD_MISALIGN_EN to allow two-beat misaligned loads.
module load_align_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  input  logic              res_ready
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                ld_ready_q, ld_ready_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
`ifdef LOAD_MISALIGN_EN
  logic                span_q, span_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
`endif

  logic [3:0]          req_bytes_c;
  logic                size_bad_c;
  logic                req_err_c;

  // Request decode: access width in bytes and illegal size/alignment detection.
  always_comb begin
    req_bytes_c = 4'd1 << ld_size;
    size_bad_c  = (DATA_W == 32) && (ld_size == 2'd3);
`ifdef LOAD_MISALIGN_EN
    req_err_c   = size_bad_c;
`else
    req_err_c   = size_bad_c ||
                  ((ld_addr[OFS_W-1:0] & OFS_W'(req_bytes_c - 4'd1)) != '0);
`endif
  end

  // Byte-lane select from the two-word window, then zero/sign extension to DATA_W.
  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W-1:0] hi,
    input logic [OFS_W-1:0]  ofs,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [2*DATA_W-1:0] win;
    logic [DATA_W-1:0]   low;
    logic [DATA_W-1:0]   val;
    logic [DATA_W-1:0]   ext;
    logic                sgn;
    win = {hi, lo} >> {ofs, 3'b000};
    low = win[DATA_W-1:0];
    case (size)
      2'd0: begin
        val = DATA_W'(low[7:0]);
        sgn = low[7];
        ext = ~DATA_W'(8'hFF);
      end
      2'd1: begin
        val = DATA_W'(low[15:0]);
        sgn = low[15];
        ext = ~DATA_W'(16'hFFFF);
      end
      2'd2: begin
        val = DATA_W'(low[31:0]);
        sgn = low[31];
        ext = ~DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        val = low;
        sgn = 1'b0;
        ext = '0;
      end
    endcase
    return (sgn && !uns) ? (val | ext) : val;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ofs_d      = ofs_q;
    size_d     = size_q;
    uns_d      = uns_q;
    mem_addr_d = mem_addr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef LOAD_MISALIGN_EN
    span_d     = span_q;
    buf0_d     = buf0_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ld_valid && ld_ready_q) begin
          ofs_d  = ld_addr[OFS_W-1:0];
          size_d = ld_size;
          uns_d  = ld_unsigned;
          if (req_err_c) begin
            state_d    = S_DONE;
            res_err_d  = 1'b1;
            res_data_d = '0;
          end else begin
            state_d    = S_REQ0;
            mem_addr_d = {ld_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
`ifdef LOAD_MISALIGN_EN
            span_d     = (32'(ld_addr[OFS_W-1:0]) + 32'(req_bytes_c)) > BYTES;
`endif
          end
        end
      end
      S_REQ0: begin
        if (mem_gnt) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_EN
          buf0_d = mem_rdata;
          if (span_q) begin
            state_d    = S_REQ1;
            mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
          end else
`endif
          begin
            state_d    = S_DONE;
            res_err_d  = 1'b0;
            res_data_d = extract(mem_rdata, '0, ofs_q, size_q, uns_q);
          end
        end
      end
`ifdef LOAD_MISALIGN_EN
      S_REQ1: begin
        if (mem_gnt) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          state_d    = S_DONE;
          res_err_d  = 1'b0;
          res_data_d = extract(buf0_q, mem_rdata, ofs_q, size_q, uns_q);
        end
      end
`endif
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ld_ready_d  = (state_d == S_IDLE);
    mem_req_d   = (state_d == S_REQ0) || (state_d == S_REQ1);
    res_valid_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ofs_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      ld_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
`ifdef LOAD_MISALIGN_EN
      span_q      <= 1'b0;
      buf0_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ofs_q       <= ofs_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      ld_ready_q  <= ld_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
`ifdef LOAD_MISALIGN_EN
      span_q      <= span_d;
      buf0_q      <= buf0_d;
`endif
    end
  end

  assign ld_ready  = ld_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: 32-bit and 64-bit instances driven through one directed task,
// checked against a byte-level memory model. Honours LOAD_MISALIGN_EN when defined.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        t_valid, t_unsigned, t_gnt, t_rvalid, t_ready;
  logic [31:0] t_addr;
  logic [1:0]  t_size;
  logic [63:0] t_rdata;

  logic        ld_ready32, mem_req32, res_valid32, res_err32;
  logic [31:0] mem_addr32, res_data32;
  logic        ld_ready64, mem_req64, res_valid64, res_err64;
  logic [31:0] mem_addr64;
  logic [63:0] res_data64;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(t_valid && !sel), .ld_ready(ld_ready32),
    .ld_addr(t_addr), .ld_size(t_size), .ld_unsigned(t_unsigned),
    .mem_req(mem_req32), .mem_addr(mem_addr32),
    .mem_gnt(t_gnt && !sel), .mem_rvalid(t_rvalid && !sel), .mem_rdata(t_rdata[31:0]),
    .res_valid(res_valid32), .res_data(res_data32), .res_err(res_err32),
    .res_ready(t_ready && !sel)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(t_valid && sel), .ld_ready(ld_ready64),
    .ld_addr(t_addr), .ld_size(t_size), .ld_unsigned(t_unsigned),
    .mem_req(mem_req64), .mem_addr(mem_addr64),
    .mem_gnt(t_gnt && sel), .mem_rvalid(t_rvalid && sel), .mem_rdata(t_rdata),
    .res_valid(res_valid64), .res_data(res_data64), .res_err(res_err64),
    .res_ready(t_ready && sel)
  );

  logic        b_ld_ready, b_mem_req, b_res_valid, b_res_err;
  logic [31:0] b_mem_addr;
  logic [63:0] b_res_data;
  assign b_ld_ready  = sel ? ld_ready64  : ld_ready32;
  assign b_mem_req   = sel ? mem_req64   : mem_req32;
  assign b_res_valid = sel ? res_valid64 : res_valid32;
  assign b_res_err   = sel ? res_err64   : res_err32;
  assign b_mem_addr  = sel ? mem_addr64  : mem_addr32;
  assign b_res_data  = sel ? res_data64  : {32'h0, res_data32};

  int n_vec = 0;
  int n_bad = 0;

  logic        exp_pending = 1'b0;
  logic        exp_err;
  logic [63:0] exp_data;
  logic [63:0] last_data;
  logic        last_err;

  logic [7:0] bmem [logic [31:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  task automatic set_word(input logic [31:0] a, input int nb, input logic [63:0] v);
    for (int i = 0; i < nb; i++) bmem[a + 32'(i)] = v[8*i +: 8];
  endtask

  function automatic logic [63:0] read_word(input logic [31:0] a, input int nb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = get_byte(a + 32'(i));
    return r;
  endfunction

  // Reference: gather n bytes little-endian from byte memory, then extend to the word width.
  function automatic void model(input int nb, input logic [31:0] a, input logic [1:0] sz,
                                input bit uns, output bit err, output logic [63:0] d,
                                output int beats);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    err = (n > nb);
`ifndef LOAD_MISALIGN_EN
    if ((a % 32'(n)) != 0) err = 1'b1;
`endif
    v = '0;
    beats = 0;
    if (!err) begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = get_byte(a + 32'(i));
      if (!uns && v[8*n-1]) for (int i = 8*n; i < 8*nb; i++) v[i] = 1'b1;
      beats = (((a % 32'(nb)) + 32'(n)) > 32'(nb)) ? 2 : 1;
    end
    d = v;
  endfunction

  // Result checker: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (b_res_valid) begin
      chk("res_expected", 64'(exp_pending), 64'(1));
      chk("res_err", 64'(b_res_err), 64'(exp_err));
      chk("res_data", b_res_data, exp_data);
    end
  end

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 64'(b_mem_req), 64'(0));
    chk("rst_res_valid", 64'(b_res_valid), 64'(0));
    chk("rst_res_err", 64'(b_res_err), 64'(0));
    chk("rst_ld_ready", 64'(b_ld_ready), 64'(0));
    chk("rst_res_data", b_res_data, 64'(0));
    chk("rst_mem_addr", 64'(b_mem_addr), 64'(0));
    exp_pending = 1'b0;
    t_valid = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0; t_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t_gnt = 1'b1; t_rvalid = 1'b1; t_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    t_gnt = 1'b0; t_rvalid = 1'b0;
    chk("stale_res_valid", 64'(b_res_valid), 64'(0));
    chk("stale_mem_req", 64'(b_mem_req), 64'(0));
    chk("post_rst_ld_ready", 64'(b_ld_ready), 64'(1));
  endtask

  // One load: gw grant-wait cycles, rw rvalid-wait cycles, yw result-wait cycles.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit uns,
                         input int gw, input int rw, input int yw, input bit rv_with_gnt,
                         input bit early_rdy, input int abort_ph);
    bit          err;
    logic [63:0] d;
    logic [63:0] held;
    logic [31:0] wa;
    int          beats;
    int          nb;
    nb = sel ? 8 : 4;
    model(nb, a, sz, uns, err, d, beats);
    @(negedge clk);
    chk("ld_ready_idle", 64'(b_ld_ready), 64'(1));
    exp_err = err; exp_data = d; exp_pending = 1'b1;
    t_valid = 1'b1; t_addr = a; t_size = sz; t_unsigned = uns;
    if (early_rdy) t_ready = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    chk("ld_ready_busy", 64'(b_ld_ready), 64'(0));
    if (err) chk("err_no_mem_req", 64'(b_mem_req), 64'(0));
    wa = a & ~32'(nb - 1);
    for (int b = 0; b < beats; b++) begin
      chk("mem_req", 64'(b_mem_req), 64'(1));
      chk("mem_addr", 64'(b_mem_addr), 64'(wa));
      if (abort_ph == 0) begin pulse_reset(); return; end
      for (int k = 0; k < gw; k++) begin
        @(negedge clk);
        chk("req_hold", 64'(b_mem_req), 64'(1));
        chk("addr_hold", 64'(b_mem_addr), 64'(wa));
        chk("ld_ready_busy", 64'(b_ld_ready), 64'(0));
      end
      t_gnt = 1'b1;
      if (rv_with_gnt) begin t_rvalid = 1'b1; t_rdata = ~read_word(wa, nb); end
      @(negedge clk);
      t_gnt = 1'b0; t_rvalid = 1'b0;
      chk("req_drop", 64'(b_mem_req), 64'(0));
      chk("early_res", 64'(b_res_valid), 64'(0));
      if (abort_ph == 1) begin pulse_reset(); return; end
      for (int k = 0; k < rw; k++) @(negedge clk);
      t_rvalid = 1'b1; t_rdata = read_word(wa, nb);
      @(negedge clk);
      t_rvalid = 1'b0;
      wa = wa + 32'(nb);
    end
    chk("res_valid_on_time", 64'(b_res_valid), 64'(1));
    if (abort_ph == 2) begin pulse_reset(); return; end
    if (!early_rdy) begin
      held = b_res_data;
      for (int k = 0; k < yw; k++) begin
        @(negedge clk);
        chk("res_hold_valid", 64'(b_res_valid), 64'(1));
        chk("res_hold_data", b_res_data, held);
        chk("ld_ready_busy", 64'(b_ld_ready), 64'(0));
        chk("done_no_mem_req", 64'(b_mem_req), 64'(0));
      end
      t_ready = 1'b1;
    end
    last_data = b_res_data;
    last_err  = b_res_err;
    @(negedge clk);
    chk("res_drop", 64'(b_res_valid), 64'(0));
    chk("ld_ready_back", 64'(b_ld_ready), 64'(1));
    @(negedge clk);
    chk("res_once", 64'(b_res_valid), 64'(0));
    t_ready = 1'b0;
    exp_pending = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0;
    t_valid = 1'b0; t_unsigned = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0; t_ready = 1'b0;
    t_addr = '0; t_size = '0; t_rdata = '0;
    #1;
    chk("reset_ld_ready32", 64'(ld_ready32), 64'(0));
    chk("reset_mem_req32", 64'(mem_req32), 64'(0));
    chk("reset_res_valid32", 64'(res_valid32), 64'(0));
    chk("reset_res_err32", 64'(res_err32), 64'(0));
    chk("reset_res_data32", 64'(res_data32), 64'(0));
    chk("reset_mem_addr32", 64'(mem_addr32), 64'(0));
    chk("reset_ld_ready64", 64'(ld_ready64), 64'(0));
    chk("reset_res_data64", res_data64, 64'(0));

    set_word(32'h100, 4, 64'h80AA_5511);
    set_word(32'h200, 4, 64'hF00D_1234);
    set_word(32'h300, 4, 64'h0BAD_F00D);
    set_word(32'h304, 4, 64'h7654_3210);
    set_word(32'h3FC, 4, 64'hAABB_CCDD);
    set_word(32'h400, 4, 64'h1122_3344);
    set_word(32'h500, 4, 64'h1234_5678);
    set_word(32'h8,   8, 64'h8000_0000_0000_0001);
    set_word(32'h10,  8, 64'h8000_0000_7F00_0000);

    @(negedge clk);
    rst_n = 1'b1;

    // 32-bit instance
    do_load(32'h103, 2'd0, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_lb_103", last_data, 64'hFFFF_FF80);
    chk("pin_lb_103_err", 64'(last_err), 64'(0));
    do_load(32'h202, 2'd1, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_lhu_202", last_data, 64'h0000_F00D);
    do_load(32'h202, 2'd1, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_lh_202", last_data, 64'hFFFF_F00D);
    do_load(32'h301, 2'd2, 1'b0, 0, 0, 2, 1'b0, 1'b0, -1);
`ifdef LOAD_MISALIGN_EN
    chk("pin_lw_301", last_data, 64'h100B_ADF0);
    chk("pin_lw_301_err", 64'(last_err), 64'(0));
`else
    chk("pin_lw_301_err", 64'(last_err), 64'(1));
    chk("pin_lw_301_data", last_data, 64'(0));
`endif
    do_load(32'h3FE, 2'd2, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
`ifdef LOAD_MISALIGN_EN
    chk("pin_lw_3fe", last_data, 64'h3344_AABB);
`else
    chk("pin_lw_3fe_err", 64'(last_err), 64'(1));
`endif
    do_load(32'h500, 2'd2, 1'b0, 3, 0, 2, 1'b0, 1'b0, -1);
    chk("pin_lw_500", last_data, 64'h1234_5678);
    do_load(32'h102, 2'd0, 1'b1, 0, 1, 0, 1'b1, 1'b0, -1);
    chk("pin_lbu_102", last_data, 64'h0000_00AA);
    do_load(32'h100, 2'd1, 1'b0, 1, 0, 0, 1'b0, 1'b1, -1);
    chk("pin_lh_100", last_data, 64'h0000_5511);
    do_load(32'h100, 2'd3, 1'b0, 0, 0, 1, 1'b0, 1'b0, -1);
    chk("pin_size3_err32", 64'(last_err), 64'(1));
    do_load(32'h100, 2'd0, 1'b0, 0, 2, 0, 1'b0, 1'b0, -1);
    do_load(32'h203, 2'd1, 1'b1, 1, 1, 1, 1'b0, 1'b0, -1);
`ifdef LOAD_MISALIGN_EN
    do_load(32'hFFFF_FFFF, 2'd1, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
`endif
    do_load(32'h103, 2'd0, 1'b0, 2, 0, 0, 1'b0, 1'b0, 0);
    do_load(32'h202, 2'd1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 2);
    do_load(32'h103, 2'd0, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_lbu_103_after_rst", last_data, 64'h0000_0080);

    // 64-bit instance
    sel = 1'b1;
    do_load(32'h8, 2'd3, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_ld_8", last_data, 64'h8000_0000_0000_0001);
    do_load(32'hC, 2'd2, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_lw_c_64", last_data, 64'hFFFF_FFFF_8000_0000);
    do_load(32'hF, 2'd0, 1'b1, 1, 0, 1, 1'b0, 1'b0, -1);
    do_load(32'h10, 2'd2, 1'b0, 0, 1, 0, 1'b0, 1'b0, -1);
    do_load(32'h13, 2'd1, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    do_load(32'h8, 2'd3, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
    do_load(32'h8, 2'd3, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);
    chk("pin_ld_8_after_rst", last_data, 64'h8000_0000_0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised, sequential load unit between the execute stage and the data-memory port.
- Accepts a load request with byte address, size and signedness, and issues aligned word reads to memory with a request/grant and variable-latency response.
- Selects the addressed bytes (little-endian), then zero- or sign-extends them.
- Returns a registered result through a valid/ready handshake.
- Replaces the purely combinational lb/lbu/lh/lhu extender with width-generic, handshaked, optionally misalign-capable behaviour.

Parameters:
- DATA_W, 32: memory/register data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- BYTES, DATA_W/8: derived, not overridable; bytes per memory word.
- OFS_W, log2(BYTES): derived; width of the byte-offset field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  unit can accept a request.
- ld_addr  in  ADDR_W  byte address.
- ld_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  aligned word address; low OFS_W bits are always 0.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- res_valid  out  1  result valid.
- res_data  out  DATA_W  extended load result.
- res_err  out  1  address/size error flag; qualified by res_valid.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low. While rst_n=0:
  - State is IDLE.
  - mem_req, res_valid, res_err, ld_ready are 0.
  - res_data, mem_addr and internal buffers are 0.
- States and transitions:
  - IDLE: ld_ready=1. On ld_valid&&ld_ready, capture addr/size/unsigned and decode:
    - error: go to DONE with res_err=1, res_data=0; no memory traffic.
    - otherwise: go to REQ0.
  - REQ0: mem_req=1, mem_addr={addr[ADDR_W-1:OFS_W],0}. Hold both stable until mem_gnt=1, then go to WAIT0.
  - WAIT0: wait for mem_rvalid=1; capture mem_rdata into buf0.
    - If the access spans two words (MISALIGN_EN only), go to REQ1.
    - Otherwise go to DONE.
  - REQ1: mem_req=1, mem_addr = first aligned address + BYTES, wrapping modulo 2^ADDR_W. Go to WAIT1 on mem_gnt.
  - WAIT1: on mem_rvalid, capture buf1, then go to DONE.
  - DONE: res_valid=1. res_data and res_err are stable until res_ready=1, then go to IDLE.
- Result calculation:
  - Offset o = addr[OFS_W-1:0]. Window = {buf1,buf0} >> (8*o).
  - Take the low 8/16/32/64 bits for the size; extend to DATA_W using bit 7/15/31/63 when ld_unsigned=0, otherwise zero-fill.
  - When there is no second beat, buf1 is treated as 0.
  - Result is computed when entering DONE and registered.
- Error conditions:
  - ld_size=3 when DATA_W=32.
  - Misaligned access (addr not a multiple of the access size) when MISALIGN_EN is not defined.
- Latency:
  - Aligned access with mem_gnt in the first REQ0 cycle and mem_rvalid one cycle later: accept at cycle 0, mem_req at cycle 1, rvalid at cycle 2, res_valid at cycle 3.
  - Error requests: res_valid at cycle 1.
- Boundary rules:
  - ld_ready is 0 outside IDLE; back-to-back requests need at least one IDLE cycle.
  - mem_rvalid outside WAIT0/WAIT1 is ignored.
  - mem_gnt and mem_rvalid both high in a REQ cycle: only the grant is consumed; data must arrive in a later cycle.
  - res_ready held high arriving in DONE: exactly one result handshake, then IDLE.
  - Reset asserted mid-transaction: mem_req and res_valid drop immediately (asynchronous); outstanding memory responses after reset release are ignored.

Optional Feature:
- Macro LOAD_MISALIGN_EN.
- Defined:
  - Misaligned half/word/dword loads are legal.
  - If o + size_bytes > BYTES, the unit performs two reads (REQ0/WAIT0, REQ1/WAIT1) and merges them; otherwise a single read.
  - res_err is only set for an illegal size.
- Not defined:
  - REQ1/WAIT1 are not built.
  - Any misaligned request returns res_err=1, res_data=0, with no memory request.

Test Plan:
- DATA_W=32: lb at addr 0x103, mem_rdata 0x80AA_5511, gnt immediate, rvalid next cycle -> res_data 0xFFFF_FF80, res_err=0, res_valid at cycle 3.
- lhu at addr 0x202, rdata 0xF00D_1234 -> res_data 0x0000_F00D; same request with lh -> 0xFFFF_F00D.
- Without LOAD_MISALIGN_EN: lw at addr 0x301 -> res_err=1, res_data=0, mem_req never asserted, res_valid at cycle 1.
- With LOAD_MISALIGN_EN: lw at addr 0x3FE, beat0 0xAABB_CCDD at 0x3FC, beat1 0x1122_3344 at 0x400 -> res_data 0x3344_AABB, two mem_req phases.
- mem_gnt withheld 3 cycles, then res_ready withheld 2 cycles -> mem_addr stable throughout REQ0, res_data/res_valid stable in DONE, ld_ready=0 until the handshake completes.
- DATA_W=64: ld (size 3) at 0x8, rdata 0x8000_0000_0000_0001 -> exact value passthrough. rst_n pulsed low during WAIT0 -> all outputs 0 immediately, IDLE with ld_ready=1 after release.
